seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits sharing one segment bus; successor to the single-digit hex decoder.
- Holds a frame-coherent copy of the display value, scans one digit per refresh slot, hex-decodes it, and applies per-digit decimal point and enable.
- Sits between status/debug registers and the board display pins.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..16).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= 4).
- BLANK_CYCLES, 16, cycles at slot start with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost).
- dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown, 0 = digit blanked.
- load  in  1  single-cycle strobe; capture value/dp/digit_en.
- seg  out  8  active-low segments, seg[7:1] = a..g, seg[0] = dp.
- an  out  NUM_DIGITS  active-low anode select, one-hot-low.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
- Reset (async assert, sync release): seg = 8'hFF, an = all 1, frame_start = 0, prescaler = 0, digit index = 0, pending flag = 0, display/pending registers = 0, display digit_en = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At wrap, the digit index advances; NUM_DIGITS-1 wraps to 0.
- Capture is double-buffered:
  - load = 1 copies the inputs into the pending registers and sets the pending flag.
  - On a digit-index wrap to 0 with pending set, pending is copied to display and the flag clears in the same cycle.
  - load arriving in that same cycle is captured as new pending, and the flag stays set.
  - Displayed data never changes mid-frame.
- frame_start pulses in the cycle the index becomes 0.
- Outputs are registered with 1-cycle latency from the index/prescaler state.
  - While prescaler < BLANK_CYCLES: an = all 1, seg = 8'hFF.
  - Otherwise: an[idx] = 0, all other an = 1, and seg = decode(display nibble idx) with seg[0] = ~dp[idx].
- If digit_en[idx] = 0, seg = 8'hFF and an stays all 1 for that slot; timing is unchanged.
- Decode table, seg[7:1]:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Index counter width is clog2(NUM_DIGITS), minimum 1. NUM_DIGITS = 1 keeps idx = 0 and frame_start pulses every slot.
- Reset mid-frame blanks the outputs immediately (async) and restarts at digit 0 with empty display data.

Optional Feature:
- SEG7_LZ_BLANK_EN defined: leading-zero suppression.
  - Starting from digit NUM_DIGITS-1 downward, each contiguous display nibble equal to 0 is treated as digit_en = 0, even when its dp is set.
  - Digit 0 is always shown if enabled.
  - The zero mask is computed from the display register only, so it is frame-coherent.
- Undefined: all enabled digits are shown, including zeros.

Test Plan:
- Common configuration: NUM_DIGITS = 4, REFRESH_DIV = 8, BLANK_CYCLES = 2.
- Reset check: assert rst_n = 0 mid-slot -> seg = FF and an = F in the same cycle; after release, the first frame_start occurs once the first wrap brings idx back to 0, and all slots are dark (display digit_en = 0).
- Basic scan: load value = 16'h1A2F, dp = 4'b0100, digit_en = F -> from the next frame, the slot sequence an = E, D, B, 7 shows seg = 0x71 (F), 0x25 (2), 0x10 (A with dp), 0x9F (1). Each slot shows seg = FF / an = F for its first 2 cycles.
- Frame coherence: load 16'h1111 mid-frame, then 16'h2222 before the frame ends -> the current frame is unchanged and the next frame shows all 2s, never 1s.
- Digit enable: digit_en = 4'b1011 -> the digit 2 slot keeps an = F and seg = FF, and slot timing is unchanged (8 cycles).
- With SEG7_LZ_BLANK_EN: value = 16'h0050 -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0. value = 16'h0000 -> only digit 0 shows 0.
- Load collision: load asserted in the same cycle as the wrap to 0 with pending set -> the old pending is displayed and the new value appears on the following frame.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for NUM_DIGITS common-anode
// 7-segment digits sharing one active-low segment bus.
//
// Ports:
//   clk, rst_n   clock; async active-low reset (release must be clk-synchronous)
//   value        hex nibbles, nibble i -> digit i (digit 0 = rightmost)
//   dp           decimal point request per digit, 1 = lit
//   digit_en     per-digit enable, 0 = digit kept dark
//   load         one-cycle strobe capturing value/dp/digit_en into pending
//   seg          active-low segments, seg[7:1] = a..g, seg[0] = dp
//   an           active-low anode select, at most one bit low
//   frame_start  one-cycle pulse as the digit 0 slot begins
//
// Build option: define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic                    p_wrap;
   logic                    f_wrap;

   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   pend_en;
   logic                    pend_flag;

   logic [4*NUM_DIGITS-1:0] disp_val;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [NUM_DIGITS-1:0]   disp_en;

   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_en;
   logic [7:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      unique case (n)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         4'hF: hex7 = 7'b0111000;
      endcase
   endfunction

   assign p_wrap = (presc == P_LAST);
   // last slot of the frame ends: index returns to digit 0 next cycle
   assign f_wrap = p_wrap && (idx == I_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc       <= '0;
         idx         <= '0;
         frame_start <= 1'b0;
      end else begin
         presc       <= p_wrap ? '0 : presc + 1'b1;
         if (p_wrap)
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
         frame_start <= f_wrap;
      end
   end

   // Double buffer: pending is promoted only at the frame boundary, so
   // the shown data never changes mid-frame. A load in the promotion
   // cycle becomes the next pending set and keeps the flag up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_en   <= '0;
         pend_flag <= 1'b0;
         disp_val  <= '0;
         disp_dp   <= '0;
         disp_en   <= '0;
      end else begin
         if (f_wrap && pend_flag) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            disp_en  <= pend_en;
         end
         if (load) begin
            pend_val  <= value;
            pend_dp   <= dp;
            pend_en   <= digit_en;
            pend_flag <= 1'b1;
         end else if (f_wrap) begin
            pend_flag <= 1'b0;
         end
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   // Dark the unbroken run of zero nibbles from the top digit down;
   // digit 0 is never part of the run.
   always_comb begin : lz_scan
      logic run;
      run     = 1'b1;
      lz_mask = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         run        = run & (disp_val[4*i +: 4] == 4'h0);
         lz_mask[i] = run;
      end
   end
`else
   assign lz_mask = '0;
`endif

   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      cur_en  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib = disp_val[4*i +: 4];
            cur_dp  = disp_dp[i];
            cur_en  = disp_en[i] & ~lz_mask[i];
         end
      end
   end

   always_comb begin
      seg_d = 8'hFF;
      an_d  = '1;
      if (presc >= P_BLANK && cur_en) begin
         seg_d = {hex7(cur_nib), ~cur_dp};
         for (int i = 0; i < NUM_DIGITS; i++)
            an_d[i] = (idx != IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 8'hFF;
         an  <= '1;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: bench for seg7_scan_driver (4 digits, 8-cycle slots,
// 2 blank cycles) with a frame-time model and literal slot expectations.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int R  = 8;
   localparam int B  = 2;
   localparam int RN = N * R;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  digit_en = '0;
   logic        load = 1'b0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R),
      .BLANK_CYCLES(B)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp         (dp),
      .digit_en   (digit_en),
      .load       (load),
      .seg        (seg),
      .an         (an),
      .frame_start(frame_start)
   );

   localparam logic [6:0] DEC [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: time measured in clock edges since reset release. Output after
   // edge k+1 shows slot (k / R) mod N at phase k mod R, using the data
   // that was on display during edge count k.
   logic [7:0]  e_seg = 8'hFF;
   logic [3:0]  e_an  = 4'hF;
   logic        e_fs  = 1'b0;
   logic [15:0] m_pv = '0, m_dv = '0;
   logic [3:0]  m_pd = '0, m_dd = '0, m_pe = '0, m_de = '0;
   logic        m_pf = 1'b0;
   int          n_edge = 0;
   int          mph, md;
   logic        mshow, mz;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            n_edge = 0;
            m_pv = '0; m_dv = '0; m_pd = '0; m_dd = '0;
            m_pe = '0; m_de = '0; m_pf = 1'b0;
            e_seg = 8'hFF; e_an = 4'hF; e_fs = 1'b0;
         end else begin
            mph   = n_edge % R;
            md    = (n_edge / R) % N;
            mshow = m_de[md];
`ifdef SEG7_LZ_BLANK_EN
            if (md > 0) begin
               mz = 1'b1;
               for (int j = md; j < N; j++)
                  if (m_dv[4*j +: 4] != 4'h0) mz = 1'b0;
               if (mz) mshow = 1'b0;
            end
`endif
            e_seg = 8'hFF;
            e_an  = 4'hF;
            if (mph >= B && mshow) begin
               e_an  = ~(4'b0001 << md);
               e_seg = {DEC[m_dv[4*md +: 4]], ~m_dd[md]};
            end
            n_edge++;
            if (n_edge % RN == 0 && m_pf) begin
               m_dv = m_pv; m_dd = m_pd; m_de = m_pe; m_pf = 1'b0;
            end
            if (load) begin
               m_pv = value; m_pd = dp; m_pe = digit_en; m_pf = 1'b1;
            end
            e_fs = (n_edge % RN == 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("seg", seg, e_seg);
            chk("an", an, e_an);
            chk("frame_start", frame_start, e_fs);
         end
      end
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                          input logic [3:0] e);
      value = v; dp = d; digit_en = e; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fs();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (frame_start) ok = 1'b1;
      end
      chk("frame_start_timeout", ok, 1);
   endtask

   // Starts on the negedge where frame_start is seen; walks one frame.
   task automatic scan_body(input string tag, input logic [31:0] segs,
                            input logic [15:0] ans);
      int p, d;
      for (int j = 1; j <= RN; j++) begin
         @(negedge clk);
         p = (j - 1) % R;
         d = (j - 1) / R;
         if (p < B) begin
            chk({tag, "_blank_seg"}, seg, 8'hFF);
            chk({tag, "_blank_an"}, an, 4'hF);
         end else if (p == 4) begin
            chk({tag, "_seg"}, seg, segs[8*d +: 8]);
            chk({tag, "_an"}, an, ans[4*d +: 4]);
         end
      end
      chk({tag, "_period"}, frame_start, 1);
   endtask

   task automatic first_fs();
      int cnt;
      bit ok;
      cnt = 0;
      ok = 1'b0;
      while (!ok && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (frame_start) ok = 1'b1;
      end
      chk("first_fs_delay", cnt, RN);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_an", an, 4'hF);
      chk("rst_fs", frame_start, 0);
      rst_n = 1'b1;
      first_fs();
      scan_body("dark", {4{8'hFF}}, 16'hFFFF);

      do_load(16'h1A2F, 4'b0100, 4'hF);
      wait_fs();
      scan_body("basic", {8'h9F, 8'h10, 8'h25, 8'h71}, 16'h7BDE);

      repeat (8) @(negedge clk);
      do_load(16'h1111, 4'h0, 4'hF);
      repeat (5) @(negedge clk);
      do_load(16'h2222, 4'h0, 4'hF);
      wait_fs();
      scan_body("coherent", {4{8'h25}}, 16'h7BDE);

      do_load(16'h1A2F, 4'h0, 4'b1011);
      wait_fs();
      scan_body("enable", {8'h9F, 8'hFF, 8'h25, 8'h71}, 16'h7FDE);

      do_load(16'h0050, 4'b1000, 4'hF);
      wait_fs();
`ifdef SEG7_LZ_BLANK_EN
      scan_body("lz_0050", {8'hFF, 8'hFF, 8'h49, 8'h03}, 16'hFFDE);
      do_load(16'h0000, 4'b1000, 4'hF);
      wait_fs();
      scan_body("lz_0000", {8'hFF, 8'hFF, 8'hFF, 8'h03}, 16'hFFFE);
`else
      scan_body("zeros", {8'h02, 8'h03, 8'h49, 8'h03}, 16'h7BDE);
`endif

      do_load(16'h3333, 4'h0, 4'hF);
      repeat (30) @(negedge clk);
      value = 16'h4444; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("collide_fs", frame_start, 1);
      scan_body("collide_old", {4{8'h0D}}, 16'h7BDE);
      scan_body("collide_new", {4{8'h99}}, 16'h7BDE);

      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_seg", seg, 8'hFF);
      chk("async_rst_an", an, 4'hF);
      chk("async_rst_fs", frame_start, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first_fs();
      scan_body("post_rst", {4{8'hFF}}, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
